// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive-clock constants, increment type and increment helper.
package uart_pkg;

  localparam int UART_CLK_HZ = 18432000;
  localparam int UART_ACC_W  = 24;
  localparam int UART_BAUD0  = 9600;
  localparam int UART_BAUD1  = 19200;
  localparam int UART_BAUD2  = 38400;
  localparam int UART_BAUD3  = 115200;

  typedef logic [UART_ACC_W-1:0] inc_t;

  // Rounded phase increment: baud * os * 2^acc_w / clk_hz, kept in 64 bits to avoid overflow.
  function automatic logic [63:0] baud_inc(input logic [63:0] clk_hz,
                                           input logic [63:0] baud,
                                           input logic [63:0] os,
                                           input int          acc_w);
    logic [63:0] num;
    num = (baud * os) << acc_w;
    return (num + (clk_hz >> 1)) / clk_hz;
  endfunction

endpackage

// File: rtl/baud_phase_acc.sv
// rtl/baud_phase_acc.sv - phase accumulator with carry-out, enable and synchronous clear.
module baud_phase_acc #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [ACC_W-1:0] inc,
  output logic             carry
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, inc};
    carry = 1'b0;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      // Bits above the carry are dropped; the fractional remainder stays in acc.
      acc_d = sum[ACC_W-1:0];
      carry = sum[ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/baudrategen_rx_frac.sv
// rtl/baudrategen_rx_frac.sv - fractional-N RX baud generator with boundary rate switching and resync.
module baudrategen_rx_frac
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = UART_CLK_HZ,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = UART_ACC_W,
  parameter int BAUD0      = UART_BAUD0,
  parameter int BAUD1      = UART_BAUD1,
  parameter int BAUD2      = UART_BAUD2,
  parameter int BAUD3      = UART_BAUD3
) (
  input  logic             clk_rx,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       baud_sel,
  input  logic             inc_override_en,
  input  logic [ACC_W-1:0] inc_override,
  input  logic             resync,
  output logic             os_tick,
  output logic             mid_tick,
  output logic             bit_tick,
  output logic             baud_clk_rx,
  output logic [ACC_W-1:0] active_inc
);

  localparam int             CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

  localparam logic [ACC_W-1:0] INC0 = ACC_W'(baud_inc(64'(CLK_HZ), 64'(BAUD0), 64'(OVERSAMPLE), ACC_W));
  localparam logic [ACC_W-1:0] INC1 = ACC_W'(baud_inc(64'(CLK_HZ), 64'(BAUD1), 64'(OVERSAMPLE), ACC_W));
  localparam logic [ACC_W-1:0] INC2 = ACC_W'(baud_inc(64'(CLK_HZ), 64'(BAUD2), 64'(OVERSAMPLE), ACC_W));
  localparam logic [ACC_W-1:0] INC3 = ACC_W'(baud_inc(64'(CLK_HZ), 64'(BAUD3), 64'(OVERSAMPLE), ACC_W));

  logic             carry;
  logic [ACC_W-1:0] requested_inc;

  logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
  logic             os_tick_q, os_tick_d;
  logic             mid_tick_q, mid_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             baud_clk_q, baud_clk_d;
  logic [ACC_W-1:0] active_inc_q, active_inc_d;

  always_comb begin
    requested_inc = INC0;
    if (inc_override_en) begin
      requested_inc = inc_override;
    end else begin
      case (baud_sel)
        2'd0:    requested_inc = INC0;
        2'd1:    requested_inc = INC1;
        2'd2:    requested_inc = INC2;
        default: requested_inc = INC3;
      endcase
    end
  end

  baud_phase_acc #(
    .ACC_W(ACC_W)
  ) u_phase_acc (
    .clk  (clk_rx),
    .rst  (rst),
    .en   (en),
    .clr  (resync),
    .inc  (active_inc_q),
    .carry(carry)
  );

  always_comb begin
    os_cnt_d     = os_cnt_q;
    os_tick_d    = 1'b0;
    mid_tick_d   = 1'b0;
    bit_tick_d   = 1'b0;
    active_inc_d = active_inc_q;
    if (resync) begin
      os_cnt_d     = '0;
      active_inc_d = requested_inc;
    end else if (!en) begin
      active_inc_d = requested_inc;
    end else if (carry) begin
      os_cnt_d   = os_cnt_q + 1'b1;
      os_tick_d  = 1'b1;
      mid_tick_d = (os_cnt_d == HALF);
      bit_tick_d = (os_cnt_q == LAST);
      // Rate changes only take effect on a bit boundary so the current bit is never distorted.
      if (bit_tick_d) begin
        active_inc_d = requested_inc;
      end
    end
    baud_clk_d = (os_cnt_d >= HALF);
  end

  always_ff @(posedge clk_rx) begin
    if (rst) begin
      os_cnt_q     <= '0;
      os_tick_q    <= 1'b0;
      mid_tick_q   <= 1'b0;
      bit_tick_q   <= 1'b0;
      baud_clk_q   <= 1'b0;
      active_inc_q <= requested_inc;
    end else begin
      os_cnt_q     <= os_cnt_d;
      os_tick_q    <= os_tick_d;
      mid_tick_q   <= mid_tick_d;
      bit_tick_q   <= bit_tick_d;
      baud_clk_q   <= baud_clk_d;
      active_inc_q <= active_inc_d;
    end
  end

  assign os_tick     = os_tick_q;
  assign mid_tick    = mid_tick_q;
  assign bit_tick    = bit_tick_q;
  assign baud_clk_rx = baud_clk_q;
  assign active_inc  = active_inc_q;

endmodule

// File: tb/tb_baudrategen_rx_frac.sv
// tb/tb_baudrategen_rx_frac.sv - directed self-checking bench for baudrategen_rx_frac.
module tb_baudrategen_rx_frac;
  import uart_pkg::*;

  localparam inc_t INC0 = 24'd139810;
  localparam inc_t INC1 = 24'd279620;
  localparam inc_t INC2 = 24'd559241;
  localparam inc_t INC3 = 24'd1677722;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] baud_sel = 2'd3;
  logic       inc_override_en = 1'b0;
  inc_t       inc_override = '0;
  logic       resync = 1'b0;
  logic       os_tick, mid_tick, bit_tick, baud_clk_rx;
  inc_t       active_inc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  baudrategen_rx_frac dut (
    .clk_rx         (clk),
    .rst            (rst),
    .en             (en),
    .baud_sel       (baud_sel),
    .inc_override_en(inc_override_en),
    .inc_override   (inc_override),
    .resync         (resync),
    .os_tick        (os_tick),
    .mid_tick       (mid_tick),
    .bit_tick       (bit_tick),
    .baud_clk_rx    (baud_clk_rx),
    .active_inc     (active_inc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // which: 0 = os_tick, 1 = mid_tick, 2 = bit_tick; returns at the negedge where it is seen
  task automatic wait_strobe(input int which, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && os_tick) || (which == 1 && mid_tick) || (which == 2 && bit_tick)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; baud_sel = 2'd3; inc_override_en = 1'b0; resync = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({os_tick, mid_tick, bit_tick, baud_clk_rx} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000", {os_tick, mid_tick, bit_tick, baud_clk_rx});
    end
    checks++;
    if (active_inc !== INC3) begin
      errors++; $display("FAIL reset_active_inc: got %0d expected %0d", active_inc, INC3);
    end
    rst = 1'b0;
  endtask

  task automatic test_rate_115200();
    bit ok;
    int t_prev, gap, bad, nines, tmo, t0, bad_first;
    bad = 0; nines = 0; tmo = 0; bad_first = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (os_tick !== (k == 10)) bad_first++;
    end
    checks++;
    if (bad_first != 0) begin
      errors++; $display("FAIL first_tick: got %0d wrong cycles expected 0 (tick after 10th edge)", bad_first);
    end
    t_prev = cyc;
    for (int i = 0; i < 40; i++) begin
      wait_strobe(0, 20, ok);
      if (!ok) tmo++;
      gap = cyc - t_prev;
      t_prev = cyc;
      if (gap == 9) nines++;
      else if (gap != 10) bad++;
    end
    checks++;
    if (bad != 0 || tmo != 0) begin
      errors++; $display("FAIL os_spacing: got %0d bad gaps %0d timeouts expected 0", bad, tmo);
    end
    checks++;
    if (nines > 1) begin
      errors++; $display("FAIL os_nine_gaps: got %0d expected <=1", nines);
    end
    wait_strobe(2, 200, ok);
    t0 = cyc;
    wait_strobe(2, 200, ok);
    checks++;
    if (!ok || cyc - t0 != 160) begin
      errors++; $display("FAIL bit_period_115200: got %0d expected 160", cyc - t0);
    end
    tmo = 0;
    for (int i = 0; i < 99; i++) begin
      wait_strobe(2, 200, ok);
      if (!ok) tmo++;
    end
    checks++;
    if (tmo != 0 || cyc - t0 < 15998 || cyc - t0 > 16002) begin
      errors++; $display("FAIL hundred_bits: got %0d cycles %0d timeouts expected 16000+-2", cyc - t0, tmo);
    end
  endtask

  task automatic test_enable();
    bit ok;
    int stray, baud_bad, n;
    stray = 0; baud_bad = 0; n = 0;
    wait_strobe(1, 200, ok);
    checks++;
    if (!ok || baud_clk_rx !== 1'b1) begin
      errors++; $display("FAIL en_mid_baud: got ok=%0d baud=%b expected ok=1 baud=1", ok, baud_clk_rx);
    end
    en = 1'b0; baud_sel = 2'd2;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (os_tick || mid_tick || bit_tick) stray++;
      if (baud_clk_rx !== 1'b1) baud_bad++;
    end
    checks++;
    if (stray != 0 || baud_bad != 0) begin
      errors++; $display("FAIL en_hold: got %0d strobes %0d baud drops expected 0 0", stray, baud_bad);
    end
    checks++;
    if (active_inc !== INC2) begin
      errors++; $display("FAIL en_load_inc: got %0d expected %0d", active_inc, INC2);
    end
    baud_sel = 2'd3;
    @(negedge clk);
    checks++;
    if (active_inc !== INC3) begin
      errors++; $display("FAIL en_reload_inc: got %0d expected %0d", active_inc, INC3);
    end
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wait_strobe(0, 20, ok);
      n++;
      if (bit_tick || !ok) break;
    end
    checks++;
    if (n != 8 || !bit_tick) begin
      errors++; $display("FAIL en_count_held: got %0d ticks to boundary expected 8", n);
    end
  endtask

  task automatic test_rate_9600();
    bit ok;
    int hi, lo, midpos, t0, tmo;
    bit last_bit;
    hi = 0; lo = 0; midpos = 0; tmo = 0; last_bit = 1'b0;
    baud_sel = 2'd0;
    wait_strobe(2, 200, ok);
    checks++;
    if (!ok || active_inc !== INC0) begin
      errors++; $display("FAIL switch_to_9600: got %0d expected %0d", active_inc, INC0);
    end
    for (int i = 0; i < 16; i++) begin
      wait_strobe(0, 200, ok);
      if (!ok) tmo++;
      if (baud_clk_rx) hi++; else lo++;
      if (mid_tick) midpos = i + 1;
      if (i == 15) last_bit = bit_tick;
    end
    checks++;
    if (hi != 8 || lo != 8 || tmo != 0) begin
      errors++; $display("FAIL duty: got hi=%0d lo=%0d expected 8 8", hi, lo);
    end
    checks++;
    if (midpos != 8 || !last_bit) begin
      errors++; $display("FAIL mid_bit_pos: got mid at %0d bit=%b expected 8 1", midpos, last_bit);
    end
    t0 = cyc;
    tmo = 0;
    for (int i = 0; i < 10; i++) begin
      wait_strobe(2, 2000, ok);
      if (!ok) tmo++;
    end
    checks++;
    if (tmo != 0 || cyc - t0 < 19199 || cyc - t0 > 19201) begin
      errors++; $display("FAIL mean_9600: got %0d cycles for 10 bits expected 19200+-1", cyc - t0);
    end
  endtask

  task automatic test_rate_change();
    bit ok;
    int t_prev, tmo;
    tmo = 0;
    t_prev = cyc;
    for (int i = 0; i < 5; i++) begin
      wait_strobe(0, 200, ok);
      if (!ok) tmo++;
    end
    baud_sel = 2'd1;
    wait_strobe(0, 200, ok);
    checks++;
    if (tmo != 0 || !ok || active_inc !== INC0) begin
      errors++; $display("FAIL deferred_inc: got %0d expected %0d", active_inc, INC0);
    end
    baud_sel = 2'd3;
    wait_strobe(2, 2000, ok);
    checks++;
    if (!ok || cyc - t_prev < 1920 || cyc - t_prev > 1921) begin
      errors++; $display("FAIL bit_before_switch: got %0d expected 1920..1921", cyc - t_prev);
    end
    checks++;
    if (active_inc !== INC3) begin
      errors++; $display("FAIL last_change_wins: got %0d expected %0d", active_inc, INC3);
    end
    t_prev = cyc;
    wait_strobe(2, 400, ok);
    checks++;
    if (!ok || cyc - t_prev < 159 || cyc - t_prev > 160) begin
      errors++; $display("FAIL bit_after_switch: got %0d expected 159..160", cyc - t_prev);
    end
  endtask

  task automatic test_resync();
    bit ok;
    int t_rs, n, tmo;
    tmo = 0; n = 0;
    for (int i = 0; i < 11; i++) begin
      wait_strobe(0, 20, ok);
      if (!ok) tmo++;
    end
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    checks++;
    if (tmo != 0 || {os_tick, mid_tick, bit_tick, baud_clk_rx} !== 4'b0000) begin
      errors++; $display("FAIL resync_clear: got %b expected 0000", {os_tick, mid_tick, bit_tick, baud_clk_rx});
    end
    t_rs = cyc;
    for (int i = 0; i < 10; i++) begin
      wait_strobe(0, 20, ok);
      n++;
      if (mid_tick || !ok) break;
    end
    checks++;
    if (!mid_tick || n != 8) begin
      errors++; $display("FAIL resync_mid_ticks: got %0d os_ticks expected 8", n);
    end
    checks++;
    if (cyc - t_rs != 80) begin
      errors++; $display("FAIL resync_mid_delay: got %0d cycles expected 80", cyc - t_rs);
    end
  endtask

  task automatic test_override_zero();
    bit ok;
    int n, stray, t0;
    n = 0; stray = 0;
    inc_override_en = 1'b1; inc_override = '0;
    for (int i = 0; i < 12; i++) begin
      wait_strobe(0, 20, ok);
      n++;
      if (bit_tick || !ok) break;
    end
    checks++;
    if (!bit_tick || n != 8) begin
      errors++; $display("FAIL override_to_boundary: got %0d ticks expected 8", n);
    end
    checks++;
    if (active_inc !== 24'd0) begin
      errors++; $display("FAIL override_zero_inc: got %0d expected 0", active_inc);
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (os_tick || mid_tick || bit_tick) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL zero_inc_stall: got %0d strobes expected 0", stray);
    end
    inc_override = INC3;
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    checks++;
    if (active_inc !== INC3) begin
      errors++; $display("FAIL resync_load_inc: got %0d expected %0d", active_inc, INC3);
    end
    t0 = cyc;
    wait_strobe(0, 30, ok);
    checks++;
    if (!ok || cyc - t0 != 10) begin
      errors++; $display("FAIL restart_tick: got %0d cycles expected 10", cyc - t0);
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    int t0;
    wait_strobe(1, 200, ok);
    checks++;
    if (!ok || baud_clk_rx !== 1'b1) begin
      errors++; $display("FAIL pre_rst_mid: got ok=%0d baud=%b expected 1 1", ok, baud_clk_rx);
    end
    inc_override_en = 1'b0; baud_sel = 2'd2; rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({os_tick, mid_tick, bit_tick, baud_clk_rx} !== 4'b0000 || active_inc !== INC2) begin
      errors++; $display("FAIL rst_mid_bit: got %b inc=%0d expected 0000 inc=%0d",
                         {os_tick, mid_tick, bit_tick, baud_clk_rx}, active_inc, INC2);
    end
    rst = 1'b0;
    repeat (45) @(negedge clk);
    rst = 1'b1; resync = 1'b1; baud_sel = 2'd1;
    @(negedge clk);
    checks++;
    if ({os_tick, mid_tick, bit_tick, baud_clk_rx} !== 4'b0000 || active_inc !== INC1) begin
      errors++; $display("FAIL rst_and_resync: got %b inc=%0d expected 0000 inc=%0d",
                         {os_tick, mid_tick, bit_tick, baud_clk_rx}, active_inc, INC1);
    end
    rst = 1'b0; resync = 1'b0;
    t0 = cyc;
    wait_strobe(0, 100, ok);
    checks++;
    if (!ok || cyc - t0 != 61) begin
      errors++; $display("FAIL first_tick_19200: got %0d cycles expected 61", cyc - t0);
    end
  endtask

  initial begin
    test_reset();
    test_rate_115200();
    test_enable();
    test_rate_9600();
    test_rate_change();
    test_resync();
    test_override_zero();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
